approx_mult_pipe: RTL and testbench

- Parametrised, pipelined 2H x 2H approximate multiplier.
- Splits each operand into high and low H-bit halves and forms four HxH quadrant products.
- Each quadrant can be exact or LSB-truncated, selected per transaction at run time.
- Quadrant products are merged either by exact shifted addition or by approximate bitwise-OR merge.
- Valid/ready streaming wrapper for approximate-arithmetic datapaths; successor to the fixed 8x8 OR-combined quadrant multipliers.

---
 rtl/approx_mult_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_approx_mult_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_pipe.sv
// ----------------------------------------------------------------------------
// approx_mult_pipe
//
// Two-stage, valid/ready pipelined 2H x 2H unsigned approximate multiplier.
// Each operand is split into H-bit halves giving four HxH quadrant products.
// A quadrant can have its low TRUNC bits zeroed (qmode, per transaction), and
// the quadrants are merged either by exact shifted addition (or_comb=0) or by
// a cheap bitwise-OR of the shifted quadrants (or_comb=1).
//
//   stage 1 (P): quadrant products + merge select, loaded on input transfer
//   stage 2 (R): merged product, loaded when P is valid and R can advance
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand/mode transaction valid
//   in_ready   block can accept a transaction this cycle (combinational)
//   a, b       unsigned operands, 2*HALF_W bits
//   qmode      per-quadrant truncate enable
//              bit0 aL*bL, bit1 aL*bH, bit2 aH*bL, bit3 aH*bH
//   or_comb    merge select: 0 shifted addition, 1 bitwise-OR merge
//   out_valid  result valid
//   out_ready  downstream accepts result
//   r          product, 4*HALF_W bits
//   err_cnt    (APPROX_ERR_STATS_EN only) saturating count of delivered
//              results that differ from the exact product a*b
//
// Optional feature macro: APPROX_ERR_STATS_EN
// ----------------------------------------------------------------------------
module approx_mult_pipe #(
    parameter int HALF_W = 4,  // quadrant width H, legal 2..16
    parameter int TRUNC  = 2   // LSBs zeroed in a truncated quadrant, 0..2H-1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   a,
    input  logic [2*HALF_W-1:0]   b,
    input  logic [3:0]            qmode,
    input  logic                  or_comb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*HALF_W-1:0]   r
`ifdef APPROX_ERR_STATS_EN
    ,
    output logic [15:0]           err_cnt
`endif
);

    localparam int OP_W = 2 * HALF_W;
    localparam int R_W  = 4 * HALF_W;

    // All-ones with the low TRUNC bits cleared; TRUNC=0 keeps every bit.
    localparam logic [OP_W-1:0] KEEP_MASK = {OP_W{1'b1}} << TRUNC;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic              s1_v_q,    s1_v_d;
    logic [OP_W-1:0]   p_ll_q,    p_ll_d;
    logic [OP_W-1:0]   p_lh_q,    p_lh_d;
    logic [OP_W-1:0]   p_hl_q,    p_hl_d;
    logic [OP_W-1:0]   p_hh_q,    p_hh_d;
    logic              or_comb_q, or_comb_d;
    logic              s2_v_q,    s2_v_d;
    logic [R_W-1:0]    r_q,       r_d;
`ifdef APPROX_ERR_STATS_EN
    logic [R_W-1:0]    exact1_q,  exact1_d;
    logic [R_W-1:0]    exact2_q,  exact2_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
`endif

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic              adv1, adv2;
    logic              in_fire, out_fire;
    logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
    logic [R_W-1:0]    merged;

    assign a_lo = a[HALF_W-1:0];
    assign a_hi = a[OP_W-1:HALF_W];
    assign b_lo = b[HALF_W-1:0];
    assign b_hi = b[OP_W-1:HALF_W];

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        s1_v_d    = s1_v_q;
        p_ll_d    = p_ll_q;
        p_lh_d    = p_lh_q;
        p_hl_d    = p_hl_q;
        p_hh_d    = p_hh_q;
        or_comb_d = or_comb_q;
        s2_v_d    = s2_v_q;
        r_d       = r_q;
`ifdef APPROX_ERR_STATS_EN
        exact1_d  = exact1_q;
        exact2_d  = exact2_q;
        err_cnt_d = err_cnt_q;
`endif

        // Stage 2 moves when empty or draining; stage 1 moves when empty or
        // when stage 2 makes room behind it.
        adv2     = !s2_v_q || out_ready;
        adv1     = !s1_v_q || adv2;
        in_fire  = in_valid && adv1;
        out_fire = s2_v_q && out_ready;

        // Stage 1: quadrant products, truncated per qmode bit.
        if (adv1) begin
            s1_v_d = in_valid;
        end
        if (in_fire) begin
            p_ll_d    = (OP_W'(a_lo) * OP_W'(b_lo)) & (qmode[0] ? KEEP_MASK : '1);
            p_lh_d    = (OP_W'(a_lo) * OP_W'(b_hi)) & (qmode[1] ? KEEP_MASK : '1);
            p_hl_d    = (OP_W'(a_hi) * OP_W'(b_lo)) & (qmode[2] ? KEEP_MASK : '1);
            p_hh_d    = (OP_W'(a_hi) * OP_W'(b_hi)) & (qmode[3] ? KEEP_MASK : '1);
            or_comb_d = or_comb;
`ifdef APPROX_ERR_STATS_EN
            exact1_d  = R_W'(a) * R_W'(b);
`endif
        end

        // Merge at full 4H width so the additive path keeps every carry.
        if (or_comb_q) begin
            merged = R_W'(p_ll_q)
                   | (R_W'(p_lh_q) << HALF_W)
                   | (R_W'(p_hl_q) << HALF_W)
                   | (R_W'(p_hh_q) << OP_W);
        end else begin
            merged = R_W'(p_ll_q)
                   + (R_W'(p_lh_q) << HALF_W)
                   + (R_W'(p_hl_q) << HALF_W)
                   + (R_W'(p_hh_q) << OP_W);
        end

        // Stage 2: r only changes when a valid stage-1 result moves in.
        if (adv2) begin
            s2_v_d = s1_v_q;
        end
        if (s1_v_q && adv2) begin
            r_d = merged;
`ifdef APPROX_ERR_STATS_EN
            exact2_d = exact1_q;
`endif
        end

`ifdef APPROX_ERR_STATS_EN
        if (out_fire && (r_q != exact2_q) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            r_q       <= '0;
`ifdef APPROX_ERR_STATS_EN
            err_cnt_q <= '0;
`endif
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            r_q       <= r_d;
`ifdef APPROX_ERR_STATS_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    // NOTE: pure datapath registers are not reset; they are qualified by the
    // stage-valid flags, so their power-up contents are never observed.
    always_ff @(posedge clk) begin
        p_ll_q    <= p_ll_d;
        p_lh_q    <= p_lh_d;
        p_hl_q    <= p_hl_d;
        p_hh_q    <= p_hh_d;
        or_comb_q <= or_comb_d;
`ifdef APPROX_ERR_STATS_EN
        exact1_q  <= exact1_d;
        exact2_q  <= exact2_d;
`endif
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = adv1;
    assign out_valid = s2_v_q;
    assign r         = r_q;
`ifdef APPROX_ERR_STATS_EN
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// ----------------------------------------------------------------------------
// tb_approx_mult_pipe
//
// Self-checking bench for approx_mult_pipe at HALF_W=4, TRUNC=2. Expected
// products come from an arithmetic reference model of the quadrant
// truncate-and-merge rules; pipeline occupancy is modelled as a plain count.
// Inputs are driven just after the falling edge, outputs sampled 1 time unit
// later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_approx_mult_pipe;

    localparam int H  = 4;
    localparam int T  = 2;
    localparam int OW = 2 * H;
    localparam int RW = 4 * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] a_i;
    logic [OW-1:0] b_i;
    logic [3:0]    qmode;
    logic          or_comb;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] r;
`ifdef APPROX_ERR_STATS_EN
    logic [15:0]   err_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    approx_mult_pipe #(.HALF_W(H), .TRUNC(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .qmode     (qmode),
        .or_comb   (or_comb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r)
`ifdef APPROX_ERR_STATS_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    // Reference: split operands arithmetically, truncate by shift-down/up,
    // weight the quadrants by powers of 2^H and combine with + or |.
    function automatic logic [RW-1:0] model(input logic [OW-1:0] aa,
                                            input logic [OW-1:0] bb,
                                            input logic [3:0]    qm,
                                            input logic          oc);
        int unsigned base;
        int unsigned q [4];
        int unsigned res;
        base = 1 << H;
        q[0] = (aa % base) * (bb % base);
        q[1] = (aa % base) * (bb / base);
        q[2] = (aa / base) * (bb % base);
        q[3] = (aa / base) * (bb / base);
        for (int i = 0; i < 4; i++) begin
            if (qm[i]) q[i] = (q[i] >> T) << T;
        end
        if (oc) res = q[0] | (q[1] * base) | (q[2] * base) | (q[3] * base * base);
        else    res = q[0] + (q[1] * base) + (q[2] * base) + (q[3] * base * base);
        return RW'(res);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends one transaction into an empty pipe with out_ready=1 and reports
    // the cycle (relative to the presenting cycle) in which out_valid rose.
    task automatic send_and_wait(input logic [OW-1:0] aa, input logic [OW-1:0] bb,
                                 input logic [3:0] qm, input logic oc,
                                 output logic [RW-1:0] got, output int lat);
        got       = 'x;
        lat       = -1;
        a_i       = aa;
        b_i       = bb;
        qmode     = qm;
        or_comb   = oc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        if (!in_ready) lat = -2;
        tick();
        in_valid = 1'b0;
        a_i      = $urandom;
        b_i      = $urandom;
        qmode    = 4'($urandom);
        or_comb  = 1'($urandom);
        for (int c = 1; c <= 10 && lat == -1; c++) begin
            #1;
            if (out_valid) begin
                got = r;
                lat = c;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_i       = '0;
        b_i       = '0;
        qmode     = '0;
        or_comb   = 1'b0;
        tick();
        tick();
        #1;
        vectors++;
        if (out_valid !== 1'b0 || r !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got out_valid=%b r=%h, expected 0 / 0000", out_valid, r);
        end
        rst = 1'b0;
        tick();
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 / 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [RW-1:0] got;
        int            lat;
        send_and_wait(8'hFF, 8'hFF, 4'b0000, 1'b0, got, lat);
        vectors++;
        if (lat !== 2 || got !== 16'hFE01) begin
            miscompares++;
            $display("FAIL exact_ff: got lat=%0d r=%h, expected 2 / fe01", lat, got);
        end
        send_and_wait(8'hFF, 8'hFF, 4'b0000, 1'b1, got, lat);
        vectors++;
        if (lat !== 2 || got !== 16'hEFF1) begin
            miscompares++;
            $display("FAIL or_merge_ff: got lat=%0d r=%h, expected 2 / eff1", lat, got);
        end
`ifdef APPROX_ERR_STATS_EN
        vectors++;
        if (err_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL err_cnt: got %0d, expected 1", err_cnt);
        end
`endif
        send_and_wait(8'hFF, 8'hFF, 4'b0001, 1'b0, got, lat);
        vectors++;
        if (lat !== 2 || got !== 16'hFE00) begin
            miscompares++;
            $display("FAIL trunc_ll: got lat=%0d r=%h, expected 2 / fe00", lat, got);
        end
        send_and_wait(8'hB7, 8'h6D, 4'b1111, 1'b0, got, lat);
        vectors++;
        if (got !== model(8'hB7, 8'h6D, 4'b1111, 1'b0)) begin
            miscompares++;
            $display("FAIL trunc_all: got %h, expected %h", got, model(8'hB7, 8'h6D, 4'b1111, 1'b0));
        end
    endtask

    task automatic test_zero_and_single();
        logic [RW-1:0] got;
        int            lat;
        for (int i = 0; i < 4; i++) begin
            send_and_wait(8'h00, 8'hAB, 4'($urandom), 1'($urandom), got, lat);
            vectors++;
            if (got !== 16'h0000) begin
                miscompares++;
                $display("FAIL zero_operand[%0d]: got %h, expected 0000", i, got);
            end
        end
        for (int oc = 0; oc < 2; oc++) begin
            send_and_wait(8'h10, 8'h01, 4'b0000, 1'(oc), got, lat);
            vectors++;
            if (got !== 16'h0010) begin
                miscompares++;
                $display("FAIL single_quadrant[or=%0d]: got %h, expected 0010", oc, got);
            end
        end
    endtask

    // Streams n transactions; out_ready follows the stall window when
    // rand_mode=0, otherwise both handshakes are randomised.
    task automatic stream(input int n, input bit rand_mode, input string tag);
        logic [RW-1:0] exp_q [$];
        int            sent      = 0;
        int            got_n     = 0;
        int            occ       = 0;
        bit            stall_prv = 1'b0;
        bit            saw_block = 1'b0;
        bit            in_fire;
        bit            out_fire;
        logic [RW-1:0] prev_r    = '0;
        for (int cyc = 0; cyc < 400 && got_n < n; cyc++) begin
            if (rand_mode) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = !(cyc >= 4 && cyc < 9);
                in_valid  = (sent < n);
            end
            a_i     = $urandom;
            b_i     = $urandom;
            qmode   = 4'($urandom);
            or_comb = 1'($urandom);
            #1;
            vectors++;
            if (in_ready !== ((occ < 2) || out_ready)) begin
                miscompares++;
                $display("FAIL %s_in_ready: cycle %0d got %b, expected %b", tag, cyc, in_ready, (occ < 2) || out_ready);
            end
            if (!in_ready) saw_block = 1'b1;
            if (stall_prv) begin
                vectors++;
                if (out_valid !== 1'b1 || r !== prev_r) begin
                    miscompares++;
                    $display("FAIL %s_stall_hold: cycle %0d got v=%b r=%h, expected 1 / %h", tag, cyc, out_valid, r, prev_r);
                end
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s_spurious: cycle %0d got %h, expected no result", tag, cyc, r);
                end else begin
                    if (r !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL %s_result[%0d]: got %h, expected %h", tag, got_n, r, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got_n++;
            end
            if (in_fire) begin
                exp_q.push_back(model(a_i, b_i, qmode, or_comb));
                sent++;
            end
            occ       = occ + int'(in_fire) - int'(out_fire);
            stall_prv = out_valid && !out_ready;
            prev_r    = r;
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (got_n !== n || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL %s_count: got %0d results, expected %0d", tag, got_n, n);
        end
        if (!rand_mode) begin
            vectors++;
            if (!saw_block) begin
                miscompares++;
                $display("FAIL %s_backpressure: got in_ready never low, expected low when 2 buffered", tag);
            end
        end
    endtask

    task automatic test_back_to_back();
        stream(8, 1'b0, "b2b");
    endtask

    task automatic test_random();
        stream(40, 1'b1, "rand");
    endtask

    task automatic test_reset_midflight();
        logic [RW-1:0] got;
        int            lat;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a_i       = 8'h3C;
        b_i       = 8'h5A;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_accept: got in_ready=%b, expected 1", in_ready);
        end
        tick();
        a_i = 8'h77;
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_full: got out_valid=%b in_ready=%b, expected 1 / 0", out_valid, in_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || r !== '0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: got v=%b r=%h rdy=%b, expected 0 / 0000 / 1", out_valid, r, in_ready);
        end
        send_and_wait(8'hC3, 8'h9E, 4'b0110, 1'b0, got, lat);
        vectors++;
        if (lat !== 2 || got !== model(8'hC3, 8'h9E, 4'b0110, 1'b0)) begin
            miscompares++;
            $display("FAIL post_reset: got lat=%0d r=%h, expected 2 / %h", lat, got, model(8'hC3, 8'h9E, 4'b0110, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_and_single();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
